pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer driving an external loadable PC counter.
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   start, start_addr    begin execution at start_addr (from IDLE or HALT)
//   pc_cnt               current value of the external PC counter
//   pc_load, pc_wdata    counter load strobe/value; counter free-increments when pc_load=0
//   mem_req, mem_addr    instruction fetch request/address
//   mem_ack, mem_rdata   fetch data valid / fetched instruction
//   ir, ir_valid         instruction register and its one-cycle update pulse
//   exec_done, jmp_en,   execute-stage handshake; jmp_en/halt_in sampled with exec_done
//   jmp_addr, halt_in
//   busy, halted, err    status (err = fetch timeout, sticky until start/reset)
//   instr_cnt            retired instruction count (mod 256)
module pc_sequencer #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] pc_cnt,
  output logic          pc_load,
  output logic [AW-1:0] pc_wdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          exec_done,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  input  logic          halt_in,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [7:0]    instr_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, HALT = 2'd3} state_t;

  // Last un-acked FETCH cycle before giving up.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t     state, nstate;
  logic [3:0] wait_cnt;
  logic       timeout_hit;

  assign timeout_hit = (wait_cnt == WAIT_LAST);
  assign busy        = (state == FETCH) || (state == EXEC);
  assign halted      = (state == HALT);

  always_comb begin
    nstate   = state;
    pc_load  = 1'b1;        // default: reload counter with itself (hold)
    pc_wdata = pc_cnt;
    mem_req  = 1'b0;
    mem_addr = pc_cnt;
    case (state)
      IDLE, HALT: begin
        // rstn gate keeps the load value at pc_cnt while reset is asserted.
        if (start && rstn) begin
          pc_wdata = start_addr;
          nstate   = FETCH;
        end
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack)          nstate = EXEC;   // ack wins over timeout
        else if (timeout_hit) nstate = HALT;
      end
      EXEC: begin
        if (exec_done) begin
          if (halt_in) begin
            nstate = HALT;                      // halt overrides jump; PC held
          end else begin
            nstate = FETCH;
            if (jmp_en) pc_wdata = jmp_addr;
            else        pc_load  = 1'b0;        // let counter step (wraps naturally)
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ir        <= '0;
      ir_valid  <= 1'b0;
      err       <= 1'b0;
      instr_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state    <= nstate;
      ir_valid <= 1'b0;
      if (nstate == FETCH && state != FETCH) wait_cnt <= '0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            instr_cnt <= '0;
            err       <= 1'b0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        EXEC: begin
          if (exec_done) instr_cnt <= instr_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
